pipeline_control: RTL

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/riscv_pkg.sv | 19 +
 rtl/pipeline_control_if.sv | 41 ++++
 rtl/hazard_detect.sv | 25 ++
 rtl/pipeline_control.sv | 138 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline-control types and constants.
package riscv_pkg;

  localparam int DRAIN_CYCLES_DEFAULT = 4;
  localparam int DRAIN_CNT_W          = 3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } pipe_ctrl_state_t;

  // x0 is hardwired zero, so a producer targeting it never creates a dependency.
  function automatic logic rd_hit(input logic [4:0] rs, input logic uses,
                                  input logic [4:0] rd, input logic wr);
    return uses && wr && (rs != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// Pipeline-to-controller signal bundle; the controller is the slave side.
interface pipeline_control_if;
  logic [4:0]  i_id_rs1_index;
  logic [4:0]  i_id_rs2_index;
  logic        i_id_uses_rs1;
  logic        i_id_uses_rs2;
  logic [4:0]  i_ex_rd_index;
  logic [4:0]  i_mem_rd_index;
  logic        i_ex_reg_write;
  logic        i_mem_reg_write;
  logic        i_ex_branch_taken;
  logic        i_mem_busy;
  logic        i_halt_req;
  logic        i_resume;
  logic        o_if_enable;
  logic        o_id_enable;
  logic        o_ex_enable;
  logic        o_mem_enable;
  logic        o_wb_enable;
  logic        o_id_flush;
  logic        o_ex_flush;
  logic        o_halted;
  logic [31:0] o_stall_cycles;
  logic [31:0] o_flush_events;

  modport master (
    output i_id_rs1_index, i_id_rs2_index, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_rd_index, i_mem_rd_index, i_ex_reg_write, i_mem_reg_write,
           i_ex_branch_taken, i_mem_busy, i_halt_req, i_resume,
    input  o_if_enable, o_id_enable, o_ex_enable, o_mem_enable, o_wb_enable,
           o_id_flush, o_ex_flush, o_halted, o_stall_cycles, o_flush_events
  );

  modport slave (
    input  i_id_rs1_index, i_id_rs2_index, i_id_uses_rs1, i_id_uses_rs2,
           i_ex_rd_index, i_mem_rd_index, i_ex_reg_write, i_mem_reg_write,
           i_ex_branch_taken, i_mem_busy, i_halt_req, i_resume,
    output o_if_enable, o_id_enable, o_ex_enable, o_mem_enable, o_wb_enable,
           o_id_flush, o_ex_flush, o_halted, o_stall_cycles, o_flush_events
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational RAW detector: decode sources against EX/MEM destinations.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [4:0] rs1_index,
  input  logic [4:0] rs2_index,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  logic [4:0] ex_rd_index,
  input  logic       ex_reg_write,
  input  logic [4:0] mem_rd_index,
  input  logic       mem_reg_write,
  output logic       raw
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rd_hit(rs1_index, uses_rs1, ex_rd_index, ex_reg_write) ||
                   rd_hit(rs1_index, uses_rs1, mem_rd_index, mem_reg_write);
  assign rs2_hit = rd_hit(rs2_index, uses_rs2, ex_rd_index, ex_reg_write) ||
                   rd_hit(rs2_index, uses_rs2, mem_rd_index, mem_reg_write);
  assign raw     = rs1_hit || rs2_hit;

endmodule

// File: rtl/pipeline_control.sv
// Pipeline stall/flush/halt controller with saturating performance counters.
//   state     | meaning
//   ST_RUN    | normal issue; services busy, branch flush and RAW stall
//   ST_DRAIN  | front end held, bubbles pushed until back end is empty
//   ST_HALTED | everything stopped, waiting for a resume pulse
module pipeline_control
  import riscv_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input logic               i_clk,
  input logic               i_rst,
  pipeline_control_if.slave bus
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  pipe_ctrl_state_t       state, state_nxt;
  logic [DRAIN_CNT_W-1:0] drain_cnt, drain_cnt_nxt;
  logic [31:0]            stall_cnt;
  logic [31:0]            flush_cnt;
  logic                   stall_inc;
  logic                   flush_inc;
  logic                   raw;

  hazard_detect u_hazard (
    .rs1_index     (bus.i_id_rs1_index),
    .rs2_index     (bus.i_id_rs2_index),
    .uses_rs1      (bus.i_id_uses_rs1),
    .uses_rs2      (bus.i_id_uses_rs2),
    .ex_rd_index   (bus.i_ex_rd_index),
    .ex_reg_write  (bus.i_ex_reg_write),
    .mem_rd_index  (bus.i_mem_rd_index),
    .mem_reg_write (bus.i_mem_reg_write),
    .raw           (raw)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  always_comb begin
    state_nxt        = state;
    drain_cnt_nxt    = drain_cnt;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    bus.o_if_enable  = 1'b1;
    bus.o_id_enable  = 1'b1;
    bus.o_ex_enable  = 1'b1;
    bus.o_mem_enable = 1'b1;
    bus.o_wb_enable  = 1'b1;
    bus.o_id_flush   = 1'b0;
    bus.o_ex_flush   = 1'b0;
    bus.o_halted     = 1'b0;

    if (i_rst) begin
      bus.o_if_enable  = 1'b0;
      bus.o_id_enable  = 1'b0;
      bus.o_ex_enable  = 1'b0;
      bus.o_mem_enable = 1'b0;
      bus.o_wb_enable  = 1'b0;
      bus.o_id_flush   = 1'b1;
      bus.o_ex_flush   = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (bus.i_mem_busy) begin
            bus.o_if_enable  = 1'b0;
            bus.o_id_enable  = 1'b0;
            bus.o_ex_enable  = 1'b0;
            bus.o_mem_enable = 1'b0;
            bus.o_wb_enable  = 1'b0;
          end else begin
            if (bus.i_ex_branch_taken) begin
              bus.o_id_flush = 1'b1;
              bus.o_ex_flush = 1'b1;
              flush_inc      = 1'b1;
            end else if (raw) begin
              bus.o_if_enable = 1'b0;
              bus.o_id_enable = 1'b0;
              bus.o_ex_flush  = 1'b1;
              stall_inc       = 1'b1;
            end
            if (bus.i_halt_req) begin
              state_nxt     = ST_DRAIN;
              drain_cnt_nxt = DRAIN_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.i_mem_busy) begin
            bus.o_if_enable  = 1'b0;
            bus.o_id_enable  = 1'b0;
            bus.o_ex_enable  = 1'b0;
            bus.o_mem_enable = 1'b0;
            bus.o_wb_enable  = 1'b0;
          end else begin
            bus.o_if_enable = 1'b0;
            bus.o_id_enable = 1'b0;
            bus.o_ex_flush  = 1'b1;
            stall_inc       = 1'b1;
            // A late branch still kills the wrong-path fetch in IF/ID.
            if (bus.i_ex_branch_taken) begin
              bus.o_id_flush = 1'b1;
              flush_inc      = 1'b1;
            end
            if (drain_cnt == '0) state_nxt = ST_HALTED;
            else drain_cnt_nxt = drain_cnt - DRAIN_CNT_W'(1);
          end
        end
        ST_HALTED: begin
          bus.o_if_enable  = 1'b0;
          bus.o_id_enable  = 1'b0;
          bus.o_ex_enable  = 1'b0;
          bus.o_mem_enable = 1'b0;
          bus.o_wb_enable  = 1'b0;
          bus.o_halted     = 1'b1;
          if (bus.i_resume) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  assign bus.o_stall_cycles = stall_cnt;
  assign bus.o_flush_events = flush_cnt;

endmodule
